// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: round-robin sharing of one BRAM port between N_MASTER
// requesters. The granted master's address/data/byte-enables are muxed onto
// the port; read data is broadcast and tagged back to the issuing master.
// Ownership changes only after all reads of the previous tenure have drained.
module bram_rr_arbiter #(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_MASTER-1:0]                 m_req,
  output logic [N_MASTER-1:0]                 m_gnt,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]      m_addr,
  input  logic [N_MASTER*DATA_WIDTH-1:0]      m_wrdata,
  input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]  m_we,
  input  logic [N_MASTER-1:0]                 m_rd,
  output logic [DATA_WIDTH-1:0]               m_rddata,
  output logic [N_MASTER-1:0]                 m_rdvalid,
  output logic [ADDR_WIDTH-1:0]               BRAM_ADDR,
  output logic [DATA_WIDTH-1:0]               BRAM_WRDATA,
  output logic [DATA_WIDTH/8-1:0]             BRAM_WE,
  output logic                                BRAM_CLK,
  input  logic [DATA_WIDTH-1:0]               BRAM_RDDATA,
  output logic                                busy
);

  localparam int IW   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int WE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_gnt_idx;
  logic [IW-1:0]         r_last_grant;
  logic [N_MASTER-1:0]   r_gnt;
  logic [2:0]            r_drain_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic                  r_tag_vld [RD_LATENCY];
  logic [IW-1:0]         r_tag_idx [RD_LATENCY];

  logic [IW-1:0]         w_winner;
  logic                  w_found;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wrdata;
  logic [WE_W-1:0]       w_sel_we;
  logic                  w_sel_rd;
  logic                  w_sel_req;
  logic                  w_rd_push;

  // Round-robin search: first requester upward from last_grant+1, with wrap.
  always_comb begin
    w_winner = r_last_grant;
    w_found  = 1'b0;
    for (int k = 1; k <= N_MASTER; k++) begin
      int j;
      j = (int'(r_last_grant) + k) % N_MASTER;
      if (!w_found && m_req[IW'(j)]) begin
        w_winner = IW'(j);
        w_found  = 1'b1;
      end
    end
  end

  // Pick out the granted master's slices.
  always_comb begin
    w_sel_addr   = '0;
    w_sel_wrdata = '0;
    w_sel_we     = '0;
    w_sel_rd     = 1'b0;
    w_sel_req    = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (r_gnt_idx == IW'(i)) begin
        w_sel_addr   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wrdata = m_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_we     = m_we[i*WE_W +: WE_W];
        w_sel_rd     = m_rd[i];
        w_sel_req    = m_req[i];
      end
    end
  end

  assign w_rd_push = (r_state == GRANT) && w_sel_rd;

  // Arbitration FSM: grant, hold for the tenure, then drain in-flight reads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_gnt_idx    <= '0;
      r_last_grant <= IW'(N_MASTER - 1);
      r_drain_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= GRANT;
            r_gnt_idx    <= w_winner;
            r_last_grant <= w_winner;
            r_gnt        <= {{(N_MASTER-1){1'b0}}, 1'b1} << w_winner;
          end
        end
        GRANT: begin
          if (!w_sel_req) begin
            r_state     <= DRAIN;
            r_gnt       <= '0;
            r_drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == 3'(RD_LATENCY - 1)) begin
            r_state <= IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Remember the last granted address so the port is stable while draining.
  always_ff @(posedge aclk) begin
    if (r_state == GRANT) begin
      r_addr_hold <= w_sel_addr;
    end
  end

  // Read-tag shift pipeline; the last stage lines up with BRAM_RDDATA.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_tag_vld[k] <= 1'b0;
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_rd_push;
      r_tag_idx[0] <= r_gnt_idx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // Decode the returning tag into a one-hot read-valid.
  always_comb begin
    m_rdvalid = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      m_rdvalid[i] = r_tag_vld[RD_LATENCY-1] && (r_tag_idx[RD_LATENCY-1] == IW'(i));
    end
  end

  // BRAM port drive: granted master in GRANT, held address in DRAIN, zero in IDLE.
  always_comb begin
    BRAM_ADDR   = '0;
    BRAM_WRDATA = '0;
    BRAM_WE     = '0;
    case (r_state)
      GRANT: begin
        BRAM_ADDR   = w_sel_addr;
        BRAM_WRDATA = w_sel_wrdata;
        BRAM_WE     = w_sel_we;
      end
      DRAIN: BRAM_ADDR = r_addr_hold;
      default: ;
    endcase
  end

  assign m_gnt    = r_gnt;
  assign m_rddata = BRAM_RDDATA;
  assign BRAM_CLK = aclk;
  assign busy     = (r_state != IDLE);

endmodule
